// File: rtl/ping_pkg.sv
// Shared definitions for the ping initiator and responder: FSM encoding and default 50 MHz timing.
// No logic; constants and a width helper only.
package ping_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_ECHO    = 3'd3,
        ST_RECOVER = 3'd4,
        ST_WAITLOW = 3'd5
    } ping_state_t;

    // Defaults at 50 MHz: 2 us / 5 us trigger window, 750 us holdoff, 58 us per cm, 200 us dead time
    localparam int TRIG_MIN_CYC_DEF = 100;
    localparam int TRIG_MAX_CYC_DEF = 250;
    localparam int HOLDOFF_CYC_DEF  = 37500;
    localparam int CYC_PER_CM_DEF   = 2900;
    localparam int RECOVER_CYC_DEF  = 10000;

    localparam int DIST_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer with edge detect; level is 2 cycles behind din, edges are single-cycle pulses.
// Edges stay masked until the pipeline holds real samples, so a line already high at reset release is not an edge.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [2:0] fill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill  <= 3'b000;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[1:0], 1'b1};
        end
    end

    assign level = sync2;
    assign rise  = fill[2] &  sync2 & ~prev;
    assign fall  = fill[2] & ~sync2 &  prev;

endmodule

// File: rtl/ping_responder.sv
// Ultrasonic-style ping target: validates a trigger pulse, waits HOLDOFF_CYC, then drives an echo of max(D,1)*CYC_PER_CM cycles.
// No flow control; the line is only driven in ECHO and input activity outside IDLE/TRIG/WAITLOW is ignored.
module ping_responder
    import ping_pkg::*;
#(
    parameter int TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
    parameter int TRIG_MAX_CYC = TRIG_MAX_CYC_DEF,
    parameter int HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
    parameter int CYC_PER_CM   = CYC_PER_CM_DEF,
    parameter int RECOVER_CYC  = RECOVER_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              SIG_IN,
    output logic              SIG_OUT,
    output logic              SIG_OE,
    input  logic [DIST_W-1:0] DIST_CM,
    output logic              BUSY,
    output logic              ECHO_DONE,
    output logic              TRIG_ERR
);

    // One shared phase counter covers trigger width, holdoff and recovery; it must hold TRIG_MAX_CYC+1
    localparam int CNT_W = $clog2(max3(TRIG_MAX_CYC + 1, HOLDOFF_CYC, RECOVER_CYC) + 1);
    localparam int CYC_W = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [CNT_W-1:0]  TRIG_MIN_C   = CNT_W'(TRIG_MIN_CYC);
    localparam logic [CNT_W-1:0]  TRIG_MAX_C   = CNT_W'(TRIG_MAX_CYC);
    localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0]  RECOVER_C    = CNT_W'(RECOVER_CYC);
    localparam logic [CYC_W-1:0]  CYC_LAST     = CYC_W'(CYC_PER_CM - 1);

    ping_state_t       state;
    ping_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [DIST_W-1:0] dist_q;

    logic line_lvl;
    logic line_rise;
    logic line_fall;
    logic in_window;
    logic too_long;
    logic holdoff_done;
    logic recover_done;
    logic echo_last;

    sync_edge u_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (SIG_IN),
        .level (line_lvl),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    // In TRIG, cnt equals the number of high cycles already seen before the current one
    assign in_window    = (cnt >= TRIG_MIN_C) && (cnt <= TRIG_MAX_C);
    assign too_long     = line_lvl && (cnt > TRIG_MAX_C);
    assign holdoff_done = (cnt == HOLDOFF_LAST);
    assign recover_done = (cnt == RECOVER_C);
    assign echo_last    = (cm_cnt == '0);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (line_rise) state_nxt = ST_TRIG;
            end
            ST_TRIG: begin
                if (line_fall)     state_nxt = in_window ? ST_HOLDOFF : ST_IDLE;
                else if (too_long) state_nxt = ST_WAITLOW;
            end
            ST_HOLDOFF: begin
                if (holdoff_done) state_nxt = ST_ECHO;
            end
            ST_ECHO: begin
                if (echo_last) state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (recover_done) state_nxt = line_lvl ? ST_WAITLOW : ST_IDLE;
            end
            ST_WAITLOW: begin
                if (!line_lvl) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state != ST_IDLE);
        SIG_OE    = (state == ST_ECHO);
        SIG_OUT   = (state == ST_ECHO) && !echo_last;
        ECHO_DONE = (state == ST_ECHO) && echo_last;
        TRIG_ERR  = (state == ST_TRIG) && ((line_fall && !in_window) || too_long);
    end

    // Echo width = cm down-counter times a per-cm cycle counter; cm_cnt reaching 0 marks the release cycle
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt     <= '0;
            cyc_cnt <= '0;
            cm_cnt  <= '0;
            dist_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= line_rise ? CNT_W'(1) : '0;
                end
                ST_TRIG: begin
                    if (line_fall && in_window) begin
                        cnt    <= CNT_W'(1);
                        dist_q <= DIST_CM;
                    end else if (line_lvl) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (holdoff_done) begin
                        cnt     <= '0;
                        cyc_cnt <= '0;
                        cm_cnt  <= (dist_q == '0) ? DIST_W'(1) : dist_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_ECHO: begin
                    if (echo_last) begin
                        cnt     <= CNT_W'(1);
                        cyc_cnt <= '0;
                    end else if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        cm_cnt  <= cm_cnt - DIST_W'(1);
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                ST_RECOVER: begin
                    cnt <= recover_done ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ping_responder.sv
// Directed bench for ping_responder with small timing parameters; cycle offsets are relative to the negedge where SIG_IN is raised.
module tb_ping_responder;

    logic       CLK;
    logic       RESET_N;
    logic       SIG_IN;
    logic       SIG_OUT;
    logic       SIG_OE;
    logic [7:0] DIST_CM;
    logic       BUSY;
    logic       ECHO_DONE;
    logic       TRIG_ERR;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int oe_rises     = 0;
    int done_n       = 0;
    int err_n        = 0;
    int oe_rise_cyc  = -1;
    int oe_fall_cyc  = -1;
    int out_rise_cyc = -1;
    int out_fall_cyc = -1;
    int done_cyc     = -1;
    int err_cyc      = -1;
    logic oe_q  = 1'b0;
    logic out_q = 1'b0;

    ping_responder #(
        .TRIG_MIN_CYC (4),
        .TRIG_MAX_CYC (20),
        .HOLDOFF_CYC  (10),
        .CYC_PER_CM   (3),
        .RECOVER_CYC  (8)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .SIG_IN    (SIG_IN),
        .SIG_OUT   (SIG_OUT),
        .SIG_OE    (SIG_OE),
        .DIST_CM   (DIST_CM),
        .BUSY      (BUSY),
        .ECHO_DONE (ECHO_DONE),
        .TRIG_ERR  (TRIG_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Event recorder: cycle numbers of output edges and pulse counts
    always @(negedge CLK) begin
        if (SIG_OE === 1'b1 && oe_q == 1'b0) begin
            oe_rises    = oe_rises + 1;
            oe_rise_cyc = cyc;
        end
        if (SIG_OE === 1'b0 && oe_q == 1'b1) oe_fall_cyc = cyc;
        if (SIG_OUT === 1'b1 && out_q == 1'b0) out_rise_cyc = cyc;
        if (SIG_OUT === 1'b0 && out_q == 1'b1) out_fall_cyc = cyc;
        if (ECHO_DONE === 1'b1) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
        if (TRIG_ERR === 1'b1) begin
            err_n   = err_n + 1;
            err_cyc = cyc;
        end
        oe_q  = (SIG_OE === 1'b1);
        out_q = (SIG_OUT === 1'b1);
    end

    task automatic pulse(input int h, output int start);
        @(negedge CLK);
        SIG_IN = 1'b1;
        start  = cyc;
        repeat (h) @(negedge CLK);
        SIG_IN = 1'b0;
    endtask

    task automatic test_reset;
        int s_oe, s_err;
        RESET_N = 1'b0;
        SIG_IN  = 1'b1;
        DIST_CM = 8'd7;
        repeat (3) @(negedge CLK);
        checks++; if (SIG_OUT !== 1'b0)   begin failures++; $display("FAIL reset_sig_out got=%b exp=0", SIG_OUT); end
        checks++; if (SIG_OE !== 1'b0)    begin failures++; $display("FAIL reset_sig_oe got=%b exp=0", SIG_OE); end
        checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (ECHO_DONE !== 1'b0) begin failures++; $display("FAIL reset_echo_done got=%b exp=0", ECHO_DONE); end
        checks++; if (TRIG_ERR !== 1'b0)  begin failures++; $display("FAIL reset_trig_err got=%b exp=0", TRIG_ERR); end
        s_oe  = oe_rises;
        s_err = err_n;
        // Line held high through reset release, then dropped after an in-window width: must not count as a trigger
        RESET_N = 1'b1;
        repeat (6) @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL held_high_busy got=%b exp=0", BUSY); end
        SIG_IN = 1'b0;
        repeat (30) @(negedge CLK);
        #1;
        checks++; if (oe_rises - s_oe != 0) begin failures++; $display("FAIL held_high_echo got=%0d exp=0", oe_rises - s_oe); end
        checks++; if (err_n - s_err != 0)   begin failures++; $display("FAIL held_high_err got=%0d exp=0", err_n - s_err); end
    endtask

    task automatic test_normal_echo;
        int a, s_oe, s_done, s_err;
        s_oe = oe_rises; s_done = done_n; s_err = err_n;
        DIST_CM = 8'd7;
        pulse(5, a);
        repeat (3) @(negedge CLK);
        checks++; if (BUSY !== 1'b1)   begin failures++; $display("FAIL holdoff_busy got=%b exp=1", BUSY); end
        checks++; if (SIG_OE !== 1'b0) begin failures++; $display("FAIL holdoff_oe got=%b exp=0", SIG_OE); end
        repeat (52) @(negedge CLK);
        #1;
        checks++; if (oe_rise_cyc - a != 17)  begin failures++; $display("FAIL echo_oe_rise got=%0d exp=17", oe_rise_cyc - a); end
        checks++; if (out_rise_cyc - a != 17) begin failures++; $display("FAIL echo_out_rise got=%0d exp=17", out_rise_cyc - a); end
        checks++; if (out_fall_cyc - out_rise_cyc != 21) begin failures++; $display("FAIL echo_width got=%0d exp=21", out_fall_cyc - out_rise_cyc); end
        checks++; if (done_cyc - a != 38)     begin failures++; $display("FAIL echo_done_cyc got=%0d exp=38", done_cyc - a); end
        checks++; if (oe_fall_cyc - a != 39)  begin failures++; $display("FAIL echo_oe_fall got=%0d exp=39", oe_fall_cyc - a); end
        checks++; if (done_n - s_done != 1)   begin failures++; $display("FAIL echo_done_count got=%0d exp=1", done_n - s_done); end
        checks++; if (oe_rises - s_oe != 1)   begin failures++; $display("FAIL echo_oe_count got=%0d exp=1", oe_rises - s_oe); end
        checks++; if (err_n - s_err != 0)     begin failures++; $display("FAIL echo_err_count got=%0d exp=0", err_n - s_err); end
        checks++; if (BUSY !== 1'b0)          begin failures++; $display("FAIL echo_idle_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_short_trigger;
        int a, s_oe, s_err;
        s_oe = oe_rises; s_err = err_n;
        pulse(2, a);
        repeat (10) @(negedge CLK);
        #1;
        checks++; if (err_n - s_err != 1) begin failures++; $display("FAIL short_err_count got=%0d exp=1", err_n - s_err); end
        checks++; if (err_cyc - a != 4)   begin failures++; $display("FAIL short_err_cyc got=%0d exp=4", err_cyc - a); end
        checks++; if (oe_rises - s_oe != 0) begin failures++; $display("FAIL short_oe_count got=%0d exp=0", oe_rises - s_oe); end
        checks++; if (BUSY !== 1'b0)      begin failures++; $display("FAIL short_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_long_trigger;
        int a, s_oe, s_err;
        s_oe = oe_rises; s_err = err_n;
        pulse(30, a);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL long_waitlow_busy got=%b exp=1", BUSY); end
        #1;
        checks++; if (err_cyc - a != 23) begin failures++; $display("FAIL long_err_cyc got=%0d exp=23", err_cyc - a); end
        repeat (10) @(negedge CLK);
        #1;
        checks++; if (err_n - s_err != 1)   begin failures++; $display("FAIL long_err_count got=%0d exp=1", err_n - s_err); end
        checks++; if (oe_rises - s_oe != 0) begin failures++; $display("FAIL long_oe_count got=%0d exp=0", oe_rises - s_oe); end
        checks++; if (BUSY !== 1'b0)        begin failures++; $display("FAIL long_idle_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_zero_distance;
        int a, s_done;
        s_done = done_n;
        DIST_CM = 8'd0;
        pulse(5, a);
        repeat (5) @(negedge CLK);
        DIST_CM = 8'd200;
        repeat (40) @(negedge CLK);
        #1;
        checks++; if (oe_rise_cyc - a != 17) begin failures++; $display("FAIL zero_oe_rise got=%0d exp=17", oe_rise_cyc - a); end
        checks++; if (out_fall_cyc - out_rise_cyc != 3) begin failures++; $display("FAIL zero_width got=%0d exp=3", out_fall_cyc - out_rise_cyc); end
        checks++; if (done_n - s_done != 1)  begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_n - s_done); end
        checks++; if (BUSY !== 1'b0)         begin failures++; $display("FAIL zero_idle_busy got=%b exp=0", BUSY); end
        DIST_CM = 8'd7;
    endtask

    task automatic test_reset_mid_echo;
        int a, b, s_done;
        s_done = done_n;
        DIST_CM = 8'd7;
        pulse(5, a);
        repeat (17) @(negedge CLK);
        checks++; if (SIG_OUT !== 1'b1) begin failures++; $display("FAIL midecho_out got=%b exp=1", SIG_OUT); end
        RESET_N = 1'b0;
        @(negedge CLK);
        checks++; if (SIG_OUT !== 1'b0) begin failures++; $display("FAIL midreset_out got=%b exp=0", SIG_OUT); end
        checks++; if (SIG_OE !== 1'b0)  begin failures++; $display("FAIL midreset_oe got=%b exp=0", SIG_OE); end
        checks++; if (BUSY !== 1'b0)    begin failures++; $display("FAIL midreset_busy got=%b exp=0", BUSY); end
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        #1;
        checks++; if (done_n - s_done != 0) begin failures++; $display("FAIL midreset_done_count got=%0d exp=0", done_n - s_done); end
        s_done = done_n;
        pulse(5, b);
        repeat (55) @(negedge CLK);
        #1;
        checks++; if (oe_rise_cyc - b != 17) begin failures++; $display("FAIL after_reset_oe_rise got=%0d exp=17", oe_rise_cyc - b); end
        checks++; if (out_fall_cyc - out_rise_cyc != 21) begin failures++; $display("FAIL after_reset_width got=%0d exp=21", out_fall_cyc - out_rise_cyc); end
        checks++; if (done_n - s_done != 1)  begin failures++; $display("FAIL after_reset_done_count got=%0d exp=1", done_n - s_done); end
    endtask

    task automatic test_back_to_back;
        int a, s_oe, s_done, s_err;
        s_oe = oe_rises; s_done = done_n; s_err = err_n;
        DIST_CM = 8'd1;
        pulse(5, a);
        repeat (15) @(negedge CLK);
        // Echo ends at +20; second trigger raised here lands inside RECOVER (+21..+28)
        SIG_IN = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if (BUSY !== 1'b1)   begin failures++; $display("FAIL recover_busy got=%b exp=1", BUSY); end
        checks++; if (SIG_OE !== 1'b0) begin failures++; $display("FAIL recover_oe got=%b exp=0", SIG_OE); end
        repeat (7) @(negedge CLK);
        checks++; if (BUSY !== 1'b1)   begin failures++; $display("FAIL waitlow_busy got=%b exp=1", BUSY); end
        repeat (8) @(negedge CLK);
        SIG_IN = 1'b0;
        repeat (10) @(negedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0)          begin failures++; $display("FAIL retrig_idle_busy got=%b exp=0", BUSY); end
        checks++; if (oe_rises - s_oe != 1)   begin failures++; $display("FAIL retrig_oe_count got=%0d exp=1", oe_rises - s_oe); end
        checks++; if (done_n - s_done != 1)   begin failures++; $display("FAIL retrig_done_count got=%0d exp=1", done_n - s_done); end
        checks++; if (err_n - s_err != 0)     begin failures++; $display("FAIL retrig_err_count got=%0d exp=0", err_n - s_err); end
        DIST_CM = 8'd7;
    endtask

    initial begin
        RESET_N = 1'b0;
        SIG_IN  = 1'b0;
        DIST_CM = 8'd0;
        test_reset();
        test_normal_echo();
        test_short_trigger();
        test_long_trigger();
        test_zero_distance();
        test_reset_mid_echo();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
